// File: rtl/pin_mux_ctrl.sv
// Sequential writer for the pin-mux map buses: applies MAP, UNMAP and CLEAR_ALL
// commands while keeping physical_map and logical_map a consistent one-to-one assignment.
module pin_mux_ctrl #(
  parameter int unsigned IO_PHYSICAL = 50,
  parameter int unsigned IO_LOGICAL  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_logical,
  input  logic [7:0]               cmd_physical,
  output logic                     rsp_done,
  output logic                     rsp_error,
  output logic                     busy,
  output logic [IO_PHYSICAL*8-1:0] physical_map,
  output logic [IO_LOGICAL*8-1:0]  logical_map
);

  localparam int unsigned MaxPins = (IO_PHYSICAL > IO_LOGICAL) ? IO_PHYSICAL : IO_LOGICAL;
  localparam logic [7:0] NumPhys = 8'(IO_PHYSICAL);
  localparam logic [7:0] NumLog  = 8'(IO_LOGICAL);
  localparam logic [7:0] LastIdx = 8'(MaxPins - 1);
  localparam logic [7:0] Unmapped = 8'hFF;

  localparam logic [1:0] OpMap   = 2'd0;
  localparam logic [1:0] OpUnmap = 2'd1;
  localparam logic [1:0] OpClear = 2'd2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StUnlink = 3'd1;
  localparam logic [2:0] StLink   = 3'd2;
  localparam logic [2:0] StClear  = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] l_q, l_d;
  logic [7:0] p_q, p_d;
  logic [7:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rerr_q, rerr_d;
  logic [7:0] pm_q [IO_PHYSICAL];
  logic [7:0] pm_d [IO_PHYSICAL];
  logic [7:0] lm_q [IO_LOGICAL];
  logic [7:0] lm_d [IO_LOGICAL];
  logic [7:0] p_old;
  logic [7:0] l_old;

  // Current owners of the captured pins; FF when the captured index has no entry.
  always_comb begin
    p_old = Unmapped;
    for (int j = 0; j < IO_LOGICAL; j++) begin
      if (l_q == j[7:0]) p_old = lm_q[j];
    end
    l_old = Unmapped;
    for (int i = 0; i < IO_PHYSICAL; i++) begin
      if (p_q == i[7:0]) l_old = pm_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    l_d     = l_q;
    p_d     = p_q;
    idx_d   = idx_q;
    err_d   = err_q;
    pm_d    = pm_q;
    lm_d    = lm_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid && ready_q) begin
          op_d  = cmd_op;
          l_d   = cmd_logical;
          p_d   = cmd_physical;
          idx_d = 8'd0;
          err_d = 1'b0;
          case (cmd_op)
            OpMap: begin
              if (cmd_logical >= NumLog || cmd_physical >= NumPhys) begin
                err_d   = 1'b1;
                state_d = StResp;
              end else begin
                state_d = StUnlink;
              end
            end
            OpUnmap: begin
              if (cmd_logical >= NumLog) begin
                err_d   = 1'b1;
                state_d = StResp;
              end else begin
                state_d = StUnlink;
              end
            end
            OpClear: state_d = StClear;
            default: begin
              err_d   = 1'b1;
              state_d = StResp;
            end
          endcase
        end
      end
      StUnlink: begin
        // Out-of-range old owners (FF) match no entry, so they are skipped naturally.
        for (int i = 0; i < IO_PHYSICAL; i++) begin
          if (p_old == i[7:0]) pm_d[i] = Unmapped;
        end
        for (int j = 0; j < IO_LOGICAL; j++) begin
          if (op_q == OpMap && l_old == j[7:0]) lm_d[j] = Unmapped;
          if (l_q == j[7:0]) lm_d[j] = Unmapped;
        end
        state_d = (op_q == OpMap) ? StLink : StResp;
      end
      StLink: begin
        for (int j = 0; j < IO_LOGICAL; j++) begin
          if (l_q == j[7:0]) lm_d[j] = p_q;
        end
        for (int i = 0; i < IO_PHYSICAL; i++) begin
          if (p_q == i[7:0]) pm_d[i] = l_q;
        end
        state_d = StResp;
      end
      StClear: begin
        for (int i = 0; i < IO_PHYSICAL; i++) begin
          if (idx_q == i[7:0]) pm_d[i] = Unmapped;
        end
        for (int j = 0; j < IO_LOGICAL; j++) begin
          if (idx_q == j[7:0]) lm_d[j] = Unmapped;
        end
        idx_d = idx_q + 8'd1;
        if (idx_q == LastIdx) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StResp);
    rerr_d  = (state_d == StResp) && err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpMap;
      l_q     <= Unmapped;
      p_q     <= Unmapped;
      idx_q   <= 8'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      for (int i = 0; i < IO_PHYSICAL; i++) pm_q[i] <= Unmapped;
      for (int j = 0; j < IO_LOGICAL; j++) lm_q[j] <= Unmapped;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      l_q     <= l_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
      pm_q    <= pm_d;
      lm_q    <= lm_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_done  = done_q;
  assign rsp_error = rerr_q;

  for (genvar g = 0; g < IO_PHYSICAL; g++) begin : g_pm
    assign physical_map[g*8 +: 8] = pm_q[g];
  end
  for (genvar g = 0; g < IO_LOGICAL; g++) begin : g_lm
    assign logical_map[g*8 +: 8] = lm_q[g];
  end

endmodule
